// File: rtl/mipspkgf.sv
// mipspkgf: shared fetch types, opcode constants and helpers.
package mipspkgf;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_HALT  = 6'd17;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_HALT_WAIT, S_HALTED} fetch_state_t;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[31:26] == OP_HALT;
    endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry in-order {pc, instr} FIFO with push/pop/flush and count.
module fetch_skid_buf
    import mipspkgf::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  if_entry_t  din,
    output if_entry_t  head,
    output logic [1:0] count
);
    if_entry_t e0, e1;
    logic pop_ok;
    logic [1:0] slot;

    assign pop_ok = pop && count != 2'd0;
    assign slot   = count - {1'b0, pop_ok};
    assign head   = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok) e0 <= e1;
            if (push && slot == 2'd0) e0 <= din;
            if (push && slot != 2'd0) e1 <= din;
            count <= slot + {1'b0, push};
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with 2-entry skid buffer, redirect and HALT handling.
// Optional FETCH_STATS_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_stage
    import mipspkgf::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 4096,
    localparam int         AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [31:0]   if_pc,
    input  logic          id_ready,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
`ifdef FETCH_STATS_EN
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   stall_cnt,
`endif
    output logic          halted
);
    fetch_state_t state, state_nx;
    logic [31:0] pc, inflight_pc, fetch_pc;
    logic inflight, redirect, push, pop;
    logic [1:0] count;
    logic [2:0] occ;
    if_entry_t head;

    assign redirect  = br_taken && (state == S_FETCH || state == S_HALT_WAIT);
    assign if_valid  = count != 2'd0 && state != S_HALTED;
    assign pop       = if_valid && id_ready;
    assign push      = inflight && state == S_FETCH && !redirect;
    assign fetch_pc  = redirect ? (br_target & ~32'h3) : pc;
    // a same-cycle pop frees a slot, which keeps steady-state throughput at one per cycle
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign imem_req  = redirect || (state == S_FETCH && occ < 3'd2);
    assign imem_addr = fetch_pc[AW-1:0] & ~AW'(3);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign halted    = state == S_HALTED;

    fetch_skid_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{pc: inflight_pc, instr: imem_rdata}),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_nx = state;
        state_nx = state == S_RESET ? S_FETCH :
                   state == S_FETCH && push && is_halt(imem_rdata) ? S_HALT_WAIT :
                   state == S_HALT_WAIT && redirect ? S_FETCH :
                   state == S_HALT_WAIT && pop && is_halt(head.instr) ? S_HALTED : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nx;
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
            if (if_valid && !id_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven per-cycle checks of fetch_stage plus reset/stats sequences.
module tb_fetch_stage;
    logic        clk = 1'b0, rst_n = 1'b0, id_ready = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0, imem_rdata = '0;
    logic        imem_req, if_valid, halted;
    logic [11:0] imem_addr;
    logic [31:0] if_instr, if_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif
    logic [31:0] mem [1024];
    int total = 0, bad = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .br_taken(br_taken), .br_target(br_target),
`ifdef FETCH_STATS_EN
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr[11:2]];

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          br;
        logic [31:0] tgt;
        bit          v;
        logic [31:0] pc;
        bit          req;
        logic [11:0] addr;
        bit          h;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit rst, rdy, br, input logic [31:0] tgt, input bit v,
                                input logic [31:0] pc, input bit req, input logic [11:0] addr, input bit h);
        vecs.push_back('{rst, rdy, br, tgt, v, pc, req, addr, h});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; id_ready = 1'b0; br_taken = 1'b0;
        #1;
        chk("rst.if_valid", 32'(if_valid), 0);
        chk("rst.imem_req", 32'(imem_req), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.if_pc", if_pc, 0);
        chk("rst.if_instr", if_instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {6'd8, 5'd0, 5'd1, 16'(i)};
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h2001_0005;
        mem[2] = 32'h0022_1822;
        mem[3] = {6'd17, 26'd0};
        mem[4] = {6'd17, 26'd0};
        // straight-line run to HALT, then br_taken ignored while halted
        add(1,1,0,0,     0,0,     1,12'h000,0);
        add(0,1,0,0,     0,0,     1,12'h004,0);
        add(0,1,0,0,     1,0,     1,12'h008,0);
        add(0,1,0,0,     1,4,     1,12'h00C,0);
        add(0,1,0,0,     1,8,     1,12'h010,0);
        add(0,1,0,0,     1,12,    0,0,      0);
        add(0,1,0,0,     0,0,     0,0,      1);
        add(0,1,1,'h40,  0,0,     0,0,      1);
        add(0,1,0,0,     0,0,     0,0,      1);
        // stall for 5 cycles, then redirect to 0x103 while full
        add(1,1,1,'h200, 0,0,     1,12'h200,0);
        add(0,1,0,0,     0,0,     1,12'h204,0);
        add(0,1,0,0,     1,'h200, 1,12'h208,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 1,'h204, 0,0,0);
        add(0,1,0,0,     1,'h204, 1,12'h20C,0);
        add(0,1,0,0,     1,'h208, 1,12'h210,0);
        add(0,0,0,0,     1,'h20C, 0,0,      0);
        add(0,0,1,'h103, 1,'h20C, 1,12'h100,0);
        add(0,1,0,0,     0,0,     1,12'h104,0);
        add(0,1,0,0,     1,'h100, 1,12'h108,0);
        add(0,1,0,0,     1,'h104, 1,12'h10C,0);
        // redirect in the same cycle the HALT response lands
        add(1,1,1,'h10,  0,0,     1,12'h010,0);
        add(0,1,1,'h40,  0,0,     1,12'h040,0);
        add(0,1,0,0,     0,0,     1,12'h044,0);
        add(0,1,0,0,     1,'h40,  1,12'h048,0);
        // redirect out of HALT_WAIT before the HALT is consumed
        add(1,0,1,'h10,  0,0,     1,12'h010,0);
        add(0,0,0,0,     0,0,     1,12'h014,0);
        add(0,0,1,'h40,  1,'h10,  1,12'h040,0);
        add(0,1,0,0,     0,0,     1,12'h044,0);
        add(0,1,0,0,     1,'h40,  1,12'h048,0);
        // address wrap at the top of memory
        add(1,1,1,'hFFC, 0,0,     1,12'hFFC,0);
        add(0,1,0,0,     0,0,     1,12'h000,0);
        add(0,1,0,0,     1,'hFFC, 1,12'h004,0);
        add(0,1,0,0,     1,'h1000,1,12'h008,0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            id_ready = vecs[i].rdy; br_taken = vecs[i].br; br_target = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d.if_valid", i), 32'(if_valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                chk($sformatf("v%0d.if_pc", i), if_pc, vecs[i].pc);
                chk($sformatf("v%0d.if_instr", i), if_instr, mem[vecs[i].pc[11:2]]);
            end
            chk($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d.halted", i), 32'(halted), 32'(vecs[i].h));
        end

        // one-cycle reset mid-stream while a response is landing
        do_reset();
        @(negedge clk); id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid.pre_valid", 32'(if_valid), 1);
        chk("mid.pre_pc", if_pc, 0);
        rst_n = 1'b0;
        #1;
        chk("mid.async_valid", 32'(if_valid), 0);
        chk("mid.async_req", 32'(imem_req), 0);
        chk("mid.async_instr", if_instr, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid.c1_valid", 32'(if_valid), 0);
        chk("mid.c1_req", 32'(imem_req), 1);
        chk("mid.c1_addr", 32'(imem_addr), 0);
        @(negedge clk); #1;
        chk("mid.c2_valid", 32'(if_valid), 0);
        @(negedge clk); #1;
        chk("mid.c3_pc", if_pc, 0);
        chk("mid.c3_instr", if_instr, mem[0]);
        @(negedge clk); #1;
        chk("mid.c4_pc", if_pc, 4);
        chk("mid.c4_instr", if_instr, mem[1]);

`ifdef FETCH_STATS_EN
        do_reset();
        chk("stats.fetch0", fetch_cnt, 0);
        chk("stats.stall0", stall_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); id_ready = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); id_ready = 1'b1;
        end
        @(negedge clk); id_ready = 1'b0;
        #1;
        chk("stats.stall", stall_cnt, 4);
        chk("stats.fetch", fetch_cnt, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
